sys_ctrl_param: RTL and testbench

//  Parametrised, single-FSM successor of the system controller. Decodes UART command frames from the RX deserialiser
//  and drives the register file and ALU. Returns responses to the TX serialiser; an ALU result is split into
//  ALU_OUT_WIDTH/DATA_WIDTH words, sent LS word first. Adds three things: an inter-byte timeout, an error response
//  for bad opcodes or stalls, and a dropped-byte flag. Sits between the UART RX/TX pair and the REG_FILE/ALU.

---
 rtl/sys_ctrl_param.sv | 185 ++++++++++++++++++
 tb/tb_sys_ctrl_param.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl_param.sv
// sys_ctrl_param: UART command-frame decoder driving REG_FILE and ALU.
// Decodes AA/BB/CC/DD frames, returns read data or ALU results (LS word first)
// to the TX serialiser, and reports bad opcodes, stalls and dropped RX words
// through ERR_FLAG plus an ERR_CODE response where a reply is owed.
module sys_ctrl_param #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ADDR_WIDTH     = 4,
  parameter int                    ALU_OUT_WIDTH  = 16,
  parameter int                    TIMEOUT_CYCLES = 4096,
  parameter logic [DATA_WIDTH-1:0] ERR_CODE       = 8'hEE
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VALID,
  input  logic [DATA_WIDTH-1:0]    RD_DATA,
  input  logic                     RD_DATA_VALID,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     OUT_VALID,
  input  logic                     BUSY,
  output logic                     ALU_EN,
  output logic [3:0]               ALU_FUN,
  output logic                     CLK_EN,
  output logic [ADDR_WIDTH-1:0]    ADDR,
  output logic                     WR_EN,
  output logic                     RD_EN,
  output logic [DATA_WIDTH-1:0]    WR_DATA,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     TX_D_VALID,
  output logic                     CLK_DIV_EN,
  output logic                     ERR_FLAG
);

  localparam int NWORDS = ALU_OUT_WIDTH / DATA_WIDTH;
  localparam int IDXW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int CW     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_WR_ADDR  = 4'd1;
  localparam logic [3:0] S_WR_DATA  = 4'd2;
  localparam logic [3:0] S_RD_ADDR  = 4'd3;
  localparam logic [3:0] S_RD_WAIT  = 4'd4;
  localparam logic [3:0] S_OP_A     = 4'd5;
  localparam logic [3:0] S_OP_B     = 4'd6;
  localparam logic [3:0] S_ALU_FN   = 4'd7;
  localparam logic [3:0] S_ALU_WAIT = 4'd8;
  localparam logic [3:0] S_TX_SEND  = 4'd9;

  localparam logic [DATA_WIDTH-1:0] OPC_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OPC_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OPC_ALU = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OPC_NOP = DATA_WIDTH'(8'hDD);

  logic [3:0]                         state;
  logic [CW-1:0]                      cnt;
  logic [NWORDS-1:0][DATA_WIDTH-1:0]  txbuf;
  logic [IDXW-1:0]                    tx_idx;
  logic [IDXW-1:0]                    tx_last;
  logic                               active;
  logic                               tmo;

  // The UART divider is never gated by this block.
  assign CLK_DIV_EN = 1'b1;

  // Timeout fires only in states that wait on a frame byte or on REG_FILE/ALU;
  // a word arriving in the same cycle takes precedence.
  always_comb begin
    active = (state != S_IDLE) && (state != S_TX_SEND);
    tmo    = active && !RX_D_VALID && (cnt == CW'(TIMEOUT_CYCLES - 1));
  end

  // Frame decode, register/ALU strobes, response buffering and TX handshake.
  // Every state change also clears the inter-byte counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= S_IDLE;
      cnt        <= '0;
      txbuf      <= '0;
      tx_idx     <= '0;
      tx_last    <= '0;
      ALU_EN     <= 1'b0;
      ALU_FUN    <= '0;
      CLK_EN     <= 1'b0;
      ADDR       <= '0;
      WR_EN      <= 1'b0;
      RD_EN      <= 1'b0;
      WR_DATA    <= '0;
      TX_P_DATA  <= '0;
      TX_D_VALID <= 1'b0;
      ERR_FLAG   <= 1'b0;
    end else begin
      WR_EN    <= 1'b0;
      RD_EN    <= 1'b0;
      ALU_EN   <= 1'b0;
      ERR_FLAG <= 1'b0;
      if (RX_D_VALID)  cnt <= '0;
      else if (active) cnt <= cnt + CW'(1);

      case (state)
        S_IDLE: if (RX_D_VALID) begin
          cnt <= '0;
          case (RX_P_DATA)
            OPC_WR:  state <= S_WR_ADDR;
            OPC_RD:  state <= S_RD_ADDR;
            OPC_ALU: state <= S_OP_A;
            OPC_NOP: begin state <= S_ALU_FN; CLK_EN <= 1'b1; end
            default: begin
              ERR_FLAG <= 1'b1;
              txbuf    <= ALU_OUT_WIDTH'(ERR_CODE);
              tx_last  <= '0;
              state    <= S_TX_SEND;
            end
          endcase
        end
        S_WR_ADDR, S_RD_ADDR, S_WR_DATA, S_OP_A, S_OP_B, S_ALU_FN: begin
          if (RX_D_VALID) begin
            cnt <= '0;
            case (state)
              S_WR_ADDR: begin ADDR <= RX_P_DATA[ADDR_WIDTH-1:0]; state <= S_WR_DATA; end
              S_WR_DATA: begin WR_DATA <= RX_P_DATA; WR_EN <= 1'b1; state <= S_IDLE; end
              S_RD_ADDR: begin ADDR <= RX_P_DATA[ADDR_WIDTH-1:0]; RD_EN <= 1'b1; state <= S_RD_WAIT; end
              S_OP_A: begin
                ADDR <= '0; WR_DATA <= RX_P_DATA; WR_EN <= 1'b1; state <= S_OP_B;
              end
              S_OP_B: begin
                ADDR <= ADDR_WIDTH'(1); WR_DATA <= RX_P_DATA; WR_EN <= 1'b1;
                CLK_EN <= 1'b1; state <= S_ALU_FN;
              end
              default: begin ALU_FUN <= RX_P_DATA[3:0]; ALU_EN <= 1'b1; state <= S_ALU_WAIT; end
            endcase
          end else if (tmo) begin
            // Stalled frame: drop it silently; the ALU clock is released too.
            ERR_FLAG <= 1'b1;
            CLK_EN   <= 1'b0;
            cnt      <= '0;
            state    <= S_IDLE;
          end
        end
        S_RD_WAIT, S_ALU_WAIT: begin
          if (RX_D_VALID) ERR_FLAG <= 1'b1;
          if (state == S_RD_WAIT && RD_DATA_VALID) begin
            txbuf   <= ALU_OUT_WIDTH'(RD_DATA);
            tx_last <= '0;
            cnt     <= '0;
            state   <= S_TX_SEND;
          end else if (state == S_ALU_WAIT && OUT_VALID) begin
            txbuf   <= ALU_OUT;
            tx_last <= IDXW'(NWORDS - 1);
            CLK_EN  <= 1'b0;
            cnt     <= '0;
            state   <= S_TX_SEND;
          end else if (tmo) begin
            ERR_FLAG <= 1'b1;
            txbuf    <= ALU_OUT_WIDTH'(ERR_CODE);
            tx_last  <= '0;
            CLK_EN   <= 1'b0;
            cnt      <= '0;
            state    <= S_TX_SEND;
          end
        end
        S_TX_SEND: begin
          if (RX_D_VALID) ERR_FLAG <= 1'b1;
          // Request held until the serialiser shows BUSY; the next word waits
          // for BUSY to fall again.
          if (TX_D_VALID) begin
            if (BUSY) begin
              TX_D_VALID <= 1'b0;
              if (tx_idx == tx_last) begin
                tx_idx <= '0;
                state  <= S_IDLE;
              end else begin
                tx_idx <= tx_idx + IDXW'(1);
              end
            end
          end else if (!BUSY) begin
            TX_P_DATA  <= txbuf[tx_idx];
            TX_D_VALID <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_ctrl_param.sv
// Scoreboard bench for sys_ctrl_param: expected writes, reads, ALU starts and
// TX words are queued as frames are driven and popped as the DUT emits them.
module tb_sys_ctrl_param;

  localparam int TMO = 64;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  RX_P_DATA = '0;
  logic        RX_D_VALID = 1'b0;
  logic [7:0]  RD_DATA = '0;
  logic        RD_DATA_VALID = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        OUT_VALID = 1'b0;
  logic        BUSY = 1'b0;
  logic        ALU_EN, CLK_EN, WR_EN, RD_EN, TX_D_VALID, CLK_DIV_EN, ERR_FLAG;
  logic [3:0]  ALU_FUN, ADDR;
  logic [7:0]  WR_DATA, TX_P_DATA;

  sys_ctrl_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_OUT_WIDTH(16),
                   .TIMEOUT_CYCLES(TMO), .ERR_CODE(8'hEE)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VALID(RX_D_VALID),
    .RD_DATA(RD_DATA), .RD_DATA_VALID(RD_DATA_VALID), .ALU_OUT(ALU_OUT),
    .OUT_VALID(OUT_VALID), .BUSY(BUSY), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
    .CLK_EN(CLK_EN), .ADDR(ADDR), .WR_EN(WR_EN), .RD_EN(RD_EN),
    .WR_DATA(WR_DATA), .TX_P_DATA(TX_P_DATA), .TX_D_VALID(TX_D_VALID),
    .CLK_DIV_EN(CLK_DIV_EN), .ERR_FLAG(ERR_FLAG));

  always #5 CLK = ~CLK;

  int n_vec = 0, n_err = 0;
  int wr_cnt = 0, tx_cnt = 0, err_cnt = 0, alu_cnt = 0;
  int e0, w0;
  logic        tx_stall = 1'b0;
  logic [11:0] wr_q[$];
  logic [3:0]  rd_q[$];
  logic [3:0]  alu_q[$];
  logic [7:0]  tx_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge CLK); RX_P_DATA = b; RX_D_VALID = 1'b1;
    @(negedge CLK); RX_D_VALID = 1'b0;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic pulse_rd(input logic [7:0] d);
    @(negedge CLK); RD_DATA = d; RD_DATA_VALID = 1'b1;
    @(negedge CLK); RD_DATA_VALID = 1'b0;
  endtask

  task automatic pulse_alu(input logic [15:0] r);
    @(negedge CLK); ALU_OUT = r; OUT_VALID = 1'b1;
    @(negedge CLK); OUT_VALID = 1'b0;
  endtask

  task automatic wait_tx;
    for (int i = 0; i < 400; i++) begin
      if (tx_q.size() == 0 && !BUSY && !TX_D_VALID) break;
      @(negedge CLK);
    end
    chk("tx_drain", tx_q.size(), 0);
  endtask

  // Strobe monitor: register-file accesses, ALU starts and error pulses.
  always @(negedge CLK) begin
    if (RST) begin
      if (WR_EN) begin
        wr_cnt++;
        if (wr_q.size() == 0) chk("wr_unexp", wr_q.size(), 1);
        else chk("wr", {ADDR, WR_DATA}, wr_q.pop_front());
      end
      if (RD_EN) begin
        if (rd_q.size() == 0) chk("rd_unexp", rd_q.size(), 1);
        else chk("rd_addr", ADDR, rd_q.pop_front());
      end
      if (ALU_EN) begin
        alu_cnt++;
        chk("alu_clk_en", CLK_EN, 1);
        if (alu_q.size() == 0) chk("alu_unexp", alu_q.size(), 1);
        else chk("alu_fun", ALU_FUN, alu_q.pop_front());
      end
      if (ERR_FLAG) err_cnt++;
    end
  end

  // TX serialiser model: answers a request two cycles late, then stays busy.
  initial begin
    logic [7:0] w;
    forever begin
      @(negedge CLK);
      if (!RST) begin BUSY = 1'b0; continue; end
      if (TX_D_VALID && !BUSY && !tx_stall) begin
        w = TX_P_DATA;
        repeat (2) begin
          @(negedge CLK);
          chk("tx_hold", {TX_D_VALID, TX_P_DATA}, {1'b1, w});
        end
        BUSY = 1'b1;
        tx_cnt++;
        if (tx_q.size() == 0) chk("tx_unexp", tx_q.size(), 1);
        else chk("tx_word", w, tx_q.pop_front());
        repeat (4) @(negedge CLK);
        BUSY = 1'b0;
      end
    end
  end

  initial begin
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_out", {ALU_EN, ALU_FUN, CLK_EN, ADDR, WR_EN, RD_EN, WR_DATA,
                    TX_P_DATA, TX_D_VALID, ERR_FLAG}, 0);
    chk("rst_div", CLK_DIV_EN, 1);
    @(negedge CLK); RST = 1'b1;
    repeat (2) @(negedge CLK);

    // Register write, no response.
    wr_q.push_back({4'h5, 8'h3C});
    w0 = tx_cnt;
    send_byte(8'hAA, 2); send_byte(8'h05, 2); send_byte(8'h3C, 10);
    chk("wr_tx_none", tx_cnt, w0);

    // Register read returns one word.
    rd_q.push_back(4'h5); tx_q.push_back(8'h3C);
    send_byte(8'hBB, 2); send_byte(8'h05, 3);
    pulse_rd(8'h3C);
    wait_tx();

    // ALU with operands, two result words LS first.
    wr_q.push_back({4'h0, 8'h07}); wr_q.push_back({4'h1, 8'h03}); alu_q.push_back(4'h0);
    send_byte(8'hCC, 2); send_byte(8'h07, 2); send_byte(8'h03, 2); send_byte(8'h00, 3);
    chk("clk_en_wait", CLK_EN, 1);
    tx_q.push_back(8'h0A); tx_q.push_back(8'h00);
    pulse_alu(16'h000A);
    wait_tx();
    chk("clk_en_done", CLK_EN, 0);

    wr_q.push_back({4'h0, 8'h12}); wr_q.push_back({4'h1, 8'h34}); alu_q.push_back(4'h5);
    send_byte(8'hCC, 1); send_byte(8'h12, 1); send_byte(8'h34, 1); send_byte(8'h05, 4);
    tx_q.push_back(8'hEF); tx_q.push_back(8'hBE);
    pulse_alu(16'hBEEF);
    wait_tx();

    // Bad opcode.
    e0 = err_cnt; tx_q.push_back(8'hEE);
    send_byte(8'h5F, 2);
    wait_tx();
    chk("bad_op_err", err_cnt - e0, 1);

    // Stalled write frame: abandoned silently.
    e0 = err_cnt; w0 = wr_cnt;
    send_byte(8'hAA, 2); send_byte(8'h05, TMO + 16);
    chk("wr_tmo_err", err_cnt - e0, 1);
    chk("wr_tmo_nowr", wr_cnt - w0, 0);

    // Gaps just under the limit keep the frame alive.
    e0 = err_cnt; wr_q.push_back({4'h9, 8'h66});
    send_byte(8'hAA, TMO - 8); send_byte(8'h09, TMO - 8); send_byte(8'h66, 4);
    chk("gap_no_err", err_cnt - e0, 0);
    chk("gap_wr", wr_q.size(), 0);

    // ALU result withheld: timeout reply, ALU clock released.
    e0 = err_cnt; alu_q.push_back(4'h2);
    send_byte(8'hDD, 2); send_byte(8'h02, 10);
    chk("dd_clk_en", CLK_EN, 1);
    tx_q.push_back(8'hEE);
    wait_tx();
    chk("dd_tmo_clk_en", CLK_EN, 0);
    chk("dd_tmo_err", err_cnt - e0, 1);

    // Word arriving while waiting on read data is dropped and flagged.
    e0 = err_cnt; rd_q.push_back(4'h7);
    send_byte(8'hBB, 1); send_byte(8'h07, 3); send_byte(8'h11, 2);
    chk("drop_err", err_cnt - e0, 1);
    tx_q.push_back(8'h5A);
    pulse_rd(8'h5A);
    wait_tx();

    // Reset while a reply is pending on the serialiser.
    e0 = err_cnt; tx_stall = 1'b1;
    send_byte(8'h5F, 10);
    chk("stall_hold", {TX_D_VALID, TX_P_DATA}, {1'b1, 8'hEE});
    chk("stall_err", err_cnt - e0, 1);
    RST = 1'b0; #1;
    chk("midrst_out", {ALU_EN, ALU_FUN, CLK_EN, ADDR, WR_EN, RD_EN, WR_DATA,
                       TX_P_DATA, TX_D_VALID, ERR_FLAG}, 0);
    chk("midrst_div", CLK_DIV_EN, 1);
    repeat (3) @(negedge CLK);
    tx_stall = 1'b0; RST = 1'b1;
    repeat (10) @(negedge CLK);
    chk("post_rst_tx", TX_D_VALID, 0);

    chk("tx_total", tx_cnt, 8);
    chk("alu_total", alu_cnt, 3);
    chk("q_left", wr_q.size() + rd_q.size() + alu_q.size() + tx_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
